mips_fetch_unit: RTL and testbench

- Multicycle-MIPS datapath slice sitting directly upstream of the control FSM.
- Holds the 8-bit program counter and the memory data register (MDR).
- Assembles the 32-bit instruction register byte-by-byte under the FSM's one-hot-per-byte irwrite strobes.
- Feeds decoded fields (op, funct, register specifiers, immediate) back to the FSM and the register file; applies the FSM's pcwrite/brnch/pcsrc controls to update the PC.

---
 rtl/mips_fetch_unit.sv | 93 +++++++++
 tb/tb_mips_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// Multicycle MIPS fetch slice: PC, MDR and byte-assembled instruction register,
// with decoded fields and PC update under control-FSM strobes.
module mips_fetch_unit #(
    parameter int WIDTH     = 8,
    parameter int JMP_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] memdata,
    input  logic [3:0]       irwrite,
    input  logic             pcwrite,
    input  logic             brnch,
    input  logic             zero,
    input  logic [1:0]       pcsrc,
    input  logic             iord,
    input  logic [WIDTH-1:0] aluresult,
    input  logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] pc,
    output logic [31:0]      instr,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] mdr,
    output logic             pcen,
    output logic             instr_valid
);

    logic [3:0]       byte_mask;
    logic [3:0]       byte_mask_next;
    logic             instr_valid_next;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] jump_target;

    assign adr   = iord ? aluout : pc;
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];
    assign imm   = instr[WIDTH-1:0];
    assign pcen  = pcwrite | (brnch & zero);

    // Upper instruction bits beyond the PC width are deliberately dropped.
    assign jump_target = {instr[WIDTH-1-JMP_SHIFT:0], {JMP_SHIFT{1'b0}}};

    always_comb begin
        pc_next = pc;
        case (pcsrc)
            2'b00:   pc_next = aluresult;
            2'b01:   pc_next = aluout;
            2'b10:   pc_next = jump_target;
            default: pc_next = pc;
        endcase
    end

    // Byte 0 marks the start of a fetch, so it restarts completion tracking.
    always_comb begin
        byte_mask_next   = byte_mask | irwrite;
        instr_valid_next = 1'b0;
        if (irwrite[0]) begin
            byte_mask_next = irwrite;
        end else begin
            instr_valid_next = (byte_mask_next == 4'b1111);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            instr       <= '0;
            mdr         <= '0;
            byte_mask   <= 4'b0000;
            instr_valid <= 1'b0;
        end else begin
            mdr         <= memdata;
            byte_mask   <= byte_mask_next;
            instr_valid <= instr_valid_next;
            if (pcen) begin
                pc <= pc_next;
            end
            for (int i = 0; i < 4; i++) begin
                if (irwrite[i]) begin
                    instr[8*i +: 8] <= memdata[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  memdata;
    logic [3:0]  irwrite;
    logic        pcwrite;
    logic        brnch;
    logic        zero;
    logic [1:0]  pcsrc;
    logic        iord;
    logic [7:0]  aluresult;
    logic [7:0]  aluout;
    logic [7:0]  adr;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [7:0]  imm;
    logic [7:0]  mdr;
    logic        pcen;
    logic        instr_valid;

    int checks = 0;
    int errors = 0;

    mips_fetch_unit #(.WIDTH(8), .JMP_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .memdata(memdata), .irwrite(irwrite),
        .pcwrite(pcwrite), .brnch(brnch), .zero(zero), .pcsrc(pcsrc),
        .iord(iord), .aluresult(aluresult), .aluout(aluout), .adr(adr),
        .pc(pc), .instr(instr), .op(op), .funct(funct), .rs(rs), .rt(rt),
        .rd(rd), .imm(imm), .mdr(mdr), .pcen(pcen), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset     = 1'b0;
        irwrite   = 4'b0000;
        pcwrite   = 1'b0;
        brnch     = 1'b0;
        zero      = 1'b0;
        pcsrc     = 2'b00;
        iord      = 1'b0;
    endtask

    task automatic load_byte(input logic [3:0] strobe, input logic [7:0] data);
        idle();
        irwrite = strobe;
        memdata = data;
        step();
    endtask

    logic [7:0] exp_pc;

    initial begin
        memdata   = 8'h00;
        aluresult = 8'h00;
        aluout    = 8'h00;
        idle();

        // reset beats every strobe in the same cycle
        reset     = 1'b1;
        irwrite   = 4'hF;
        memdata   = 8'hAA;
        pcwrite   = 1'b1;
        aluresult = 8'h55;
        step();
        step();
        check("rst_pc", pc, 8'h00);
        check("rst_instr", instr, 32'h0);
        check("rst_mdr", mdr, 8'h00);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_adr", adr, 8'h00);

        // byte-by-byte fetch
        load_byte(4'b0001, 8'h20);
        check("f0_mdr", mdr, 8'h20);
        check("f0_instr", instr, 32'h0000_0020);
        load_byte(4'b0010, 8'h00);
        load_byte(4'b0100, 8'h01);
        check("f2_valid", instr_valid, 1'b0);
        check("f2_op", op, 6'h00);
        load_byte(4'b1000, 8'h80);
        check("f3_instr", instr, 32'h8001_0020);
        check("f3_op", op, 6'b100000);
        check("f3_funct", funct, 6'h20);
        check("f3_rt", rt, 5'd1);
        check("f3_rs", rs, 5'd0);
        check("f3_rd", rd, 5'd0);
        check("f3_imm", imm, 8'h20);
        check("f3_mdr", mdr, 8'h80);
        check("f3_valid", instr_valid, 1'b1);
        idle();
        step();
        check("hold_instr", instr, 32'h8001_0020);
        check("hold_valid", instr_valid, 1'b1);

        // PC increment through the wrap
        idle();
        pcwrite   = 1'b1;
        aluresult = 8'hFE;
        step();
        check("pc_fe", pc, 8'hFE);
        exp_pc = 8'hFE;
        for (int i = 0; i < 3; i++) begin
            aluresult = exp_pc + 8'd1;
            step();
            exp_pc = exp_pc + 8'd1;
            check("pc_inc", pc, {24'h0, exp_pc});
        end
        check("adr_pc", adr, 8'h01);

        // conditional branch
        idle();
        brnch  = 1'b1;
        pcsrc  = 2'b01;
        aluout = 8'h3C;
        zero   = 1'b0;
        #1;
        check("br_nt_pcen", pcen, 1'b0);
        step();
        check("br_nt_pc", pc, 8'h01);
        zero = 1'b1;
        #1;
        check("br_t_pcen", pcen, 1'b1);
        step();
        check("br_t_pc", pc, 8'h3C);
        iord   = 1'b1;
        aluout = 8'h77;
        #1;
        check("adr_aluout", adr, 8'h77);

        // jump, then reserved select
        load_byte(4'b0001, 8'h05);
        load_byte(4'b0010, 8'h00);
        load_byte(4'b0100, 8'h00);
        load_byte(4'b1000, 8'h08);
        check("j_instr", instr, 32'h0800_0005);
        idle();
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        step();
        check("jump_pc", pc, 8'h14);
        pcsrc = 2'b11;
        step();
        check("resv_pc", pc, 8'h14);

        // jump uses pre-edge instr while byte 0 reloads in the same cycle
        pcsrc     = 2'b00;
        aluresult = 8'h00;
        step();
        check("pc_zero", pc, 8'h00);
        pcsrc   = 2'b10;
        irwrite = 4'b0001;
        memdata = 8'h09;
        step();
        check("sim_pc", pc, 8'h14);
        check("sim_instr", instr, 32'h0800_0009);
        check("sim_valid", instr_valid, 1'b0);
        irwrite = 4'b0000;
        step();
        check("sim_pc2", pc, 8'h24);

        // restart mid-fetch
        load_byte(4'b0001, 8'h11);
        load_byte(4'b0010, 8'h22);
        load_byte(4'b0001, 8'h33);
        check("rs_valid0", instr_valid, 1'b0);
        load_byte(4'b0010, 8'h44);
        load_byte(4'b0100, 8'h55);
        check("rs_valid2", instr_valid, 1'b0);
        load_byte(4'b1000, 8'h66);
        check("rs_valid3", instr_valid, 1'b1);
        check("rs_instr", instr, 32'h6655_4433);

        // reset between bytes 2 and 3 discards the partial word
        load_byte(4'b0001, 8'hA1);
        load_byte(4'b0010, 8'hB2);
        load_byte(4'b0100, 8'hC3);
        idle();
        reset   = 1'b1;
        irwrite = 4'b1000;
        memdata = 8'hD4;
        step();
        check("mr_instr", instr, 32'h0);
        check("mr_valid", instr_valid, 1'b0);
        check("mr_pc", pc, 8'h00);
        load_byte(4'b1000, 8'hD4);
        check("mr_b3_instr", instr, 32'hD400_0000);
        check("mr_b3_valid", instr_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
